// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for elastic pipeline stages: state encoding, default
// widths and the state-to-occupancy decode.
package pipe_stage_elastic_pkg;

  localparam int DEF_DATA_W = 96;
  localparam int DEF_CTRL_W = 14;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } elastic_state_e;

  function automatic logic [1:0] state_occupancy(input elastic_state_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One payload+control holding register with load enable and synchronous clear.
// It carries no valid bit; validity is tracked by the owning stage's state.
module pipe_slot_reg
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Slot contents: reset/clear dominate, then load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data <= {DATA_W{1'b0}};
      ctrl <= {CTRL_W{1'b0}};
    end else if (load) begin
      data <= load_data;
      ctrl <= load_ctrl;
    end else begin
      data <= data;
      ctrl <= ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline stage (main + skid slot) with valid/ready
// handshake, flush and control masking on bubbles.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int CTRL_W         = DEF_CTRL_W,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  elastic_state_e    state_r;
  elastic_state_e    state_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              main_load_s;
  logic              main_from_skid_s;
  logic              skid_load_s;
  logic              clear_s;
  logic [DATA_W-1:0] main_data_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic [DATA_W-1:0] skid_data_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [DATA_W-1:0] main_next_data_s;
  logic [CTRL_W-1:0] main_next_ctrl_s;

  // Handshake outputs depend only on the state register, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready   = (state_r != ST_FULL);
  assign out_valid  = (state_r != ST_EMPTY);
  assign occupancy  = state_occupancy(state_r);
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;
  assign clear_s    = flush & CLEAR_ON_FLUSH;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and slot load decisions; flush overrides every handshake.
  always_comb begin
    state_s          = state_r;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_s     = ST_ONE;
            main_load_s = 1'b1;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_s     = ST_ONE;
            main_load_s = 1'b1;
          end else if (in_fire_s) begin
            state_s     = ST_FULL;
            skid_load_s = 1'b1;
          end else if (out_fire_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_s          = ST_ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Main slot refills from skid when draining FULL, else from upstream.
  always_comb begin
    main_next_data_s = in_data;
    main_next_ctrl_s = in_ctrl;
    if (main_from_skid_s) begin
      main_next_data_s = skid_data_s;
      main_next_ctrl_s = skid_ctrl_s;
    end else begin
      main_next_data_s = in_data;
      main_next_ctrl_s = in_ctrl;
    end
  end

  pipe_slot_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_s),
    .load      (main_load_s),
    .load_data (main_next_data_s),
    .load_ctrl (main_next_ctrl_s),
    .data      (main_data_s),
    .ctrl      (main_ctrl_s)
  );

  pipe_slot_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_s),
    .load      (skid_load_s),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .data      (skid_data_s),
    .ctrl      (skid_ctrl_s)
  );

  // Bubbles must never assert regwrite or any other control bit.
  assign out_data = main_data_s;
  assign out_ctrl = main_ctrl_s & {CTRL_W{out_valid}};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios with literal
// expectations plus randomized traffic against a two-entry FIFO model.
module tb_pipe_stage_elastic;

  localparam int DW = 96;
  localparam int CW = 14;

  typedef logic [CW+DW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  bit   zero_known = 1'b1;
  bit   last_in_fire = 1'b0;
  bit   chk_en = 1'b0;

  pipe_stage_elastic #(
    .DATA_W         (DW),
    .CTRL_W         (CW),
    .CLEAR_ON_FLUSH (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most two entries, updated on each edge.
  initial begin
    forever begin
      bit in_fire;
      bit out_fire;
      @(posedge clk);
      in_fire  = in_valid && (q.size() < 2);
      out_fire = out_ready && (q.size() > 0);
      last_in_fire = in_fire;
      if (reset) begin
        q.delete();
        zero_known = 1'b1;
      end else if (flush) begin
        q.delete();
        zero_known = 1'b1;
      end else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire) begin
          q.push_back({in_ctrl, in_data});
          zero_known = 1'b0;
        end
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("occupancy", occupancy, q.size());
        if (q.size() > 0) begin
          chk("out_data", out_data, q[0][DW-1:0]);
          chk("out_ctrl", out_ctrl, q[0][CW+DW-1:DW]);
        end else begin
          chk("bubble_ctrl", out_ctrl, 0);
          if (zero_known) chk("cleared_data", out_data, 0);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic fl, input logic rs);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic          pv;
    logic [DW-1:0] pd;
    logic [CW-1:0] pc;

    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("preload_ctrl", out_ctrl, 0);
    chk("preload_occ", occupancy, 0);

    // First load: 1-cycle latency.
    step(1'b1, 96'hA, 14'h3FFF, 1'b1, 1'b0, 1'b0);
    chk("load_valid", out_valid, 1);
    chk("load_data", out_data, 96'hA);
    chk("load_ctrl", out_ctrl, 14'h3FFF);
    chk("load_occ", occupancy, 1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream at full throughput.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_data", out_data, i);
      chk("stream_ready", in_ready, 1);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Stall fills main then skid; third entry held upstream.
    step(1'b1, 96'h11, 14'h1, 1'b0, 1'b0, 1'b0);
    chk("stall_occ1", occupancy, 1);
    step(1'b1, 96'h22, 14'h2, 1'b0, 1'b0, 1'b0);
    chk("stall_occ2", occupancy, 2);
    chk("stall_ready", in_ready, 0);
    step(1'b1, 96'h33, 14'h3, 1'b0, 1'b0, 1'b0);
    chk("stall_head", out_data, 96'h11);
    step(1'b1, 96'h33, 14'h3, 1'b1, 1'b0, 1'b0);
    chk("drain_22", out_data, 96'h22);
    step(1'b1, 96'h33, 14'h3, 1'b1, 1'b0, 1'b0);
    chk("drain_33", out_data, 96'h33);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", occupancy, 0);

    // Flush from FULL drops both entries and the concurrent input.
    step(1'b1, 96'h44, 14'h4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'h55, 14'h5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'h66, 14'h6, 1'b0, 1'b1, 1'b0);
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    chk("flush_data", out_data, 0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_dropped", out_valid, 0);

    // Reset mid-operation from FULL.
    step(1'b1, 96'h77, 14'h7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'h88, 14'h8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'h99, 14'h9, 1'b1, 1'b0, 1'b1);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_occ", occupancy, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_ctrl", out_ctrl, 0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Random traffic; upstream holds its entry until it is accepted.
    pv = 1'b0;
    pd = '0;
    pc = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!pv || last_in_fire) begin
        pv = ($urandom_range(0, 9) < 7);
        pd = {$urandom(), $urandom(), $urandom()};
        pc = CW'($urandom());
      end
      step(pv, pd, pc, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 499) == 0));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
